// File: rtl/barrett_pkg.sv
// Shared defaults, latency helper and sideband layout for the Barrett reduction stream.
package barrett_pkg;

    localparam int unsigned WIDTH_DEF   = 64;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned TAG_W_DEF   = 8;
    localparam int unsigned K_W_DEF     = $clog2(WIDTH_DEF) + 1;

    // Enabled cycles from input acceptance to valid_o.
    function automatic int unsigned barrett_latency(input int unsigned mul_lat);
        return 2 * mul_lat + 4;
    endfunction

    // Sideband carried beside the multipliers, at default widths.
    typedef struct packed {
        logic [2*WIDTH_DEF-1:0] x;
        logic [WIDTH_DEF-1:0]   q;
        logic [K_W_DEF-1:0]     k;
        logic [TAG_W_DEF-1:0]   tag;
    } barrett_side_t;

endpackage

// File: rtl/barrett_mul_pipe.sv
// Full-width unsigned multiplier followed by a LAT-deep register pipe, advanced only on en_i.
module barrett_mul_pipe
    import barrett_pkg::*;
#(
    parameter int unsigned A_W = WIDTH_DEF + 1,
    parameter int unsigned B_W = WIDTH_DEF + 1,
    parameter int unsigned LAT = MUL_LAT_DEF
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    output logic [A_W+B_W-1:0] p_o
);

    localparam int unsigned P_W = A_W + B_W;

    logic [P_W-1:0] r_p [LAT];

    // Extra stages give synthesis room to retime the multiplier.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_p[0] <= P_W'(a_i) * P_W'(b_i);
            for (int unsigned i = 1; i < LAT; i++) begin
                r_p[i] <= r_p[i-1];
            end
        end
    end

    assign p_o = r_p[LAT-1];

endmodule

// File: rtl/barrett_reduce_stream.sv
// Streaming Barrett reduction r = x mod q with per-item modulus and constant, fixed latency,
// and a single global stall enable driven by output backpressure.
module barrett_reduce_stream
    import barrett_pkg::*;
#(
    parameter int unsigned  WIDTH   = WIDTH_DEF,
    parameter int unsigned  MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned  TAG_W   = TAG_W_DEF,
    localparam int unsigned K_W     = $clog2(WIDTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2*WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0]   q_i,
    input  logic [K_W-1:0]     k_i,
    input  logic [WIDTH:0]     mu_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   r_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int unsigned L = barrett_latency(MUL_LAT);

    // Width-generic twin of barrett_side_t; index i of r_side is aligned with pipeline stage i.
    typedef struct packed {
        logic [2*WIDTH-1:0] x;
        logic [WIDTH-1:0]   q;
        logic [K_W-1:0]     k;
        logic [TAG_W-1:0]   tag;
    } side_t;

    logic               w_en;
    side_t              r_side [L];
    logic [L-1:0]       r_vld;
    logic [WIDTH:0]     r_mu;
    logic [WIDTH:0]     r_qhat;
    logic [WIDTH+1:0]   r_r0;
    logic [WIDTH+1:0]   r_r1;
    logic               r_vld_o;
    logic [WIDTH-1:0]   r_res;
    logic [TAG_W-1:0]   r_tag;

    logic [K_W-1:0]     w_sh_t1;
    logic [K_W-1:0]     w_sh_qhat;
    logic [WIDTH:0]     w_t1;
    logic [WIDTH:0]     w_qhat;
    logic [2*WIDTH+1:0] w_p1;
    logic [2*WIDTH:0]   w_p2;
    logic [WIDTH+1:0]   w_r0;
    logic [WIDTH+1:0]   w_q_a;
    logic [WIDTH+1:0]   w_q_b;
    logic [WIDTH+1:0]   w_r1;
    logic [WIDTH-1:0]   w_r2;

    assign w_en    = !(r_vld_o && !ready_i);
    assign ready_o = w_en;

    assign w_sh_t1   = r_side[0].k - K_W'(1);
    assign w_t1      = (WIDTH+1)'(r_side[0].x >> w_sh_t1);
    assign w_sh_qhat = r_side[MUL_LAT].k + K_W'(1);
    assign w_qhat    = (WIDTH+1)'(w_p1 >> w_sh_qhat);

    // Only the low WIDTH+2 bits matter: the true remainder estimate is below 3q.
    assign w_r0  = (WIDTH+2)'(r_side[2*MUL_LAT+1].x) - (WIDTH+2)'(w_p2);
    assign w_q_a = {2'b00, r_side[L-2].q};
    assign w_r1  = (r_r0 >= w_q_a) ? (r_r0 - w_q_a) : r_r0;
    assign w_q_b = {2'b00, r_side[L-1].q};
    assign w_r2  = WIDTH'((r_r1 >= w_q_b) ? (r_r1 - w_q_b) : r_r1);

    barrett_mul_pipe #(
        .A_W (WIDTH + 1),
        .B_W (WIDTH + 1),
        .LAT (MUL_LAT)
    ) u_mul_mu (
        .clk_i (clk_i),
        .en_i  (w_en),
        .a_i   (w_t1),
        .b_i   (r_mu),
        .p_o   (w_p1)
    );

    barrett_mul_pipe #(
        .A_W (WIDTH + 1),
        .B_W (WIDTH),
        .LAT (MUL_LAT)
    ) u_mul_q (
        .clk_i (clk_i),
        .en_i  (w_en),
        .a_i   (r_qhat),
        .b_i   (r_side[MUL_LAT+1].q),
        .p_o   (w_p2)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld   <= '0;
            r_vld_o <= 1'b0;
            r_res   <= '0;
            r_tag   <= '0;
        end else if (w_en) begin
            r_vld   <= {r_vld[L-2:0], valid_i};
            r_vld_o <= r_vld[L-1];
            r_res   <= w_r2;
            r_tag   <= r_side[L-1].tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_side[0] <= side_t'{x: x_i, q: q_i, k: k_i, tag: tag_i};
            for (int unsigned i = 1; i < L; i++) begin
                r_side[i] <= r_side[i-1];
            end
            r_mu   <= mu_i;
            r_qhat <= w_qhat;
            r_r0   <= w_r0;
            r_r1   <= w_r1;
        end
    end

    assign valid_o = r_vld_o;
    assign r_o     = r_res;
    assign tag_o   = r_tag;

endmodule

// File: tb/tb_barrett_reduce_stream.sv
// Self-checking bench: x mod q reference queue, per-transfer compare, directed literal vectors.
module tb_barrett_reduce_stream;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned K_W     = $clog2(WIDTH) + 1;
    localparam int unsigned L       = 12;

    localparam logic [15:0] Q_A  = 16'd12289;
    localparam logic [4:0]  K_A  = 5'd14;
    localparam logic [16:0] MU_A = 17'd21843;
    localparam logic [15:0] Q_B  = 16'd65521;
    localparam logic [4:0]  K_B  = 5'd16;
    localparam logic [16:0] MU_B = 17'd65551;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2*WIDTH-1:0] in_x = '0;
    logic [WIDTH-1:0]   in_q = '0;
    logic [K_W-1:0]     in_k = '0;
    logic [WIDTH:0]     in_mu = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_r;
    logic [TAG_W-1:0]   out_tag;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        int unsigned      e;
    } exp_t;

    exp_t        q_exp[$];
    exp_t        m_e;
    int unsigned en_cnt = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned n_out = 0;
    int unsigned base;
    logic        bp_done;

    always #5 clk = ~clk;

    barrett_reduce_stream #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .x_i     (in_x),
        .q_i     (in_q),
        .k_i     (in_k),
        .mu_i    (in_mu),
        .tag_i   (in_tag),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .r_o     (out_r),
        .tag_o   (out_tag)
    );

    function automatic logic [WIDTH-1:0] model_mod(input logic [31:0] x, input logic [15:0] q);
        longint unsigned xx = longint'(x);
        longint unsigned qq = longint'(q);
        return WIDTH'(xx % qq);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle compare; latency counted in enabled cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d, expected no output", out_tag);
                end else begin
                    m_e = q_exp.pop_front();
                    check("r_o", 64'(out_r), 64'(m_e.r));
                    check("tag_o", 64'(out_tag), 64'(m_e.tag));
                    check("latency", 64'(en_cnt), 64'(m_e.e + L + 1));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back('{r: model_mod(in_x, in_q), tag: in_tag, e: en_cnt});
            end
            if (in_ready) en_cnt++;
        end
    end

    task automatic send(input logic [31:0] x, input logic [15:0] q, input logic [4:0] k,
                        input logic [16:0] mu, input logic [7:0] tag);
        logic        acc = 1'b0;
        int unsigned n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_q     = q;
        in_k     = k;
        in_mu    = mu;
        in_tag   = tag;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got no acceptance, expected one within 200 cycles");
                acc = 1'b1;
            end
        end
    endtask

    task automatic single(input logic [31:0] x, input logic [15:0] q, input logic [4:0] k,
                          input logic [16:0] mu, input logic [15:0] exp_r, input logic [7:0] tag);
        send(x, q, k, mu, tag);
        in_valid = 1'b0;
        repeat (L - 1) @(posedge clk);
        #1;
        check("valid_before_L", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("valid_at_L", 64'(out_valid), 64'd1);
        check("r_at_L", 64'(out_r), 64'(exp_r));
        check("tag_at_L", 64'(out_tag), 64'(tag));
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (q_exp.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(q_exp.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_valid_o", 64'(out_valid), 64'd0);
        check("reset_r_o", 64'(out_r), 64'd0);
        check("reset_tag_o", 64'(out_tag), 64'd0);
        check("reset_ready_o", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed reductions with hand-computed remainders
        single(32'd150994944, Q_A, K_A, MU_A, 16'd1, 8'h01);
        single(32'd12289, Q_A, K_A, MU_A, 16'd0, 8'h02);
        single(32'd12288, Q_A, K_A, MU_A, 16'd12288, 8'h03);
        single(32'd0, Q_A, K_A, MU_A, 16'd0, 8'h04);
        single(32'd268435455, Q_A, K_A, MU_A, 16'd6828, 8'h05);
        single(32'hFFFF_FFFF, Q_B, K_B, MU_B, 16'd224, 8'h06);
        single(32'd65521, Q_B, K_B, MU_B, 16'd0, 8'h07);
        drain();

        // Back-to-back streaming
        base = n_out;
        for (int i = 0; i < 1000; i++) begin
            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(i));
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", 64'(n_out - base), 64'd1000);

        // Alternating modulus
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(128 + i));
            else            send($urandom, Q_B, K_B, MU_B, 8'(128 + i));
        end
        in_valid = 1'b0;
        drain();

        // Full pipeline, then a 5-cycle output stall with an item waiting at the input
        for (int i = 0; i < 20; i++) begin
            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(64 + i));
        end
        in_x      = 32'd99999;
        in_tag    = 8'hC0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready_o", 64'(in_ready), 64'd0);
            check("stall_valid_o", 64'(out_valid), 64'd1);
            check("stall_r_o", 64'(out_r), 64'(q_exp[0].r));
            check("stall_tag_o", 64'(out_tag), 64'(q_exp[0].tag));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'd99999, Q_A, K_A, MU_A, 8'hC0);
        for (int i = 0; i < 10; i++) begin
            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(200 + i));
        end
        in_valid = 1'b0;
        drain();

        // Random valid gaps against random backpressure
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    if (i % 3 == 0) send($urandom, Q_B, K_B, MU_B, 8'(i));
                    else            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(i));
                end
                in_valid = 1'b0;
                bp_done  = 1'b1;
            end
            begin
                while (!bp_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with six items in flight, the oldest already on the output
        for (int i = 0; i < 6; i++) begin
            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(224 + i));
        end
        in_valid = 1'b0;
        repeat (L - 5) @(posedge clk);
        #1;
        check("pre_reset_valid_o", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_valid_o", 64'(out_valid), 64'd0);
        check("async_reset_r_o", 64'(out_r), 64'd0);
        check("async_reset_tag_o", 64'(out_tag), 64'd0);
        q_exp.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_stale_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        base = n_out;
        for (int i = 0; i < 5; i++) begin
            send($urandom & 32'h0FFF_FFFF, Q_A, K_A, MU_A, 8'(240 + i));
        end
        in_valid = 1'b0;
        drain();
        check("post_reset_count", 64'(n_out - base), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
